ysyx_25020047_seq: RTL and testbench
====================================

YSYX_25020047_SEQ -- requirements
Module: ysyx_25020047_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum wait cycles for ifu_rvalid/lsu_ack before abort.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ifu_req  out  1  fetch request at current pc.
REQ-007 ifu_rvalid  in  1  instruction returned, one-cycle pulse.
REQ-008 exu_result  in  32  EXU result (address, ALU value or branch target).
REQ-009 exu_read / exu_write / exu_reg_wen  in  1 each  EXU load, store and writeback flags.
REQ-010 pc_from_res  in  1  next pc = exu_result (jal/jalr/beq/bne).
REQ-011 ebreak / illegal  in  1 each  decoded ebreak / unknown instruction.
REQ-012 lsu_req  out  1  memory request; lsu_we  out  1  store when high.
REQ-013 lsu_ack  in  1  memory completion pulse.
REQ-014 pc  out  32  current instruction address.
REQ-015 rf_wen  out  1  register-file write strobe, one cycle per instruction.
REQ-016 halt  out  1  core stopped; halt_code  out  2  01 good trap, 10 abort, 11 timeout.
REQ-017 state_o  out  3  FSM state encoding, debug only.

Function
REQ-018 SHALL implement states FETCH(0), WAIT_I(1), EXEC(2), MEM(3), WB(4), HALT(5).
REQ-019 FETCH: assert ifu_req for exactly one cycle, then go to WAIT_I.
REQ-020 WAIT_I: on ifu_rvalid go to EXEC; the IDU/EXU outputs SHALL be sampled in EXEC, one cycle after ifu_rvalid.
REQ-021 EXEC priority: illegal -> HALT code 10; else ebreak -> HALT code 01; else exu_read|exu_write -> MEM; else WB.
REQ-022 MEM: lsu_req high and lsu_we=exu_write, held until lsu_ack; on lsu_ack go to WB.
REQ-023 lsu_req and lsu_ack in the same cycle SHALL be legal; ack latency 0 allowed.
REQ-024 WB: rf_wen = exu_reg_wen for one cycle; pc <= pc_from_res ? exu_result : pc+4; then FETCH.
REQ-025 pc SHALL update only in WB; pc arithmetic SHALL be 32-bit modulo (0xFFFF_FFFC+4 = 0).
REQ-026 exu_read and exu_write both high SHALL be treated as illegal (HALT code 10).
REQ-027 Wait counter SHALL clear on entry to WAIT_I/MEM and increment each waiting cycle; at MEM_TIMEOUT without response -> HALT code 11.
REQ-028 HALT SHALL be absorbing: no ifu_req, lsu_req or rf_wen, pc frozen, until rst.
REQ-029 A stray ifu_rvalid or lsu_ack outside WAIT_I/MEM SHALL be ignored.
REQ-030 Latency per non-memory instruction SHALL be 3 cycles + fetch wait; memory instructions add 1 + ack wait.

Reset
REQ-031 rst SHALL force state FETCH, pc=RESET_PC, counter=0, halt=0, halt_code=00, all strobes 0, on the next edge.
REQ-032 rst asserted mid-operation (WAIT_I, MEM or HALT) SHALL abandon the transaction; a late ack after reset falls under REQ-029.
REQ-033 First ifu_req SHALL be asserted in the first cycle after rst deasserts.

Structure
REQ-034 State encodings, halt codes and RESET_PC default SHALL reside in a shared package ysyx_25020047_pkg.
REQ-035 The wait-counter/timeout SHALL be a sub-module ysyx_25020047_wdog (clear, enable, expired).
REQ-036 All outputs except state_o SHALL be decoded from registered state; no combinational path from lsu_ack to lsu_req.

Verification
REQ-037 addi-like: rvalid after 2 cycles, reg_wen=1 -> one rf_wen pulse, pc 0x8000_0000 -> 0x8000_0004, 5 cycles total.
REQ-038 beq taken: pc_from_res=1, exu_result=0x8000_0100 -> pc=0x8000_0100 in WB, rf_wen=0.
REQ-039 lw with lsu_ack after 3 cycles -> lsu_req high 4 cycles, lsu_we=0, then rf_wen pulse; sw -> lsu_we=1, no rf_wen.
REQ-040 ebreak -> halt=1, code 01, no further ifu_req; illegal -> code 10.
REQ-041 no ifu_rvalid for MEM_TIMEOUT cycles -> halt code 11; rst then restarts at RESET_PC.
REQ-042 rst pulsed in MEM, then lsu_ack arrives -> ack ignored, FETCH at 0x8000_0000.

Source files
------------

// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 multi-cycle instruction sequencer.
// Contents:
//   DEFAULT_RESET_PC / DEFAULT_MEM_TIMEOUT  default values for the top-level parameters
//   state_e      FSM state encoding, which is also visible on state_o
//   halt_code_e  reason the core stopped
//   exu_pkt_t    IDU/EXU outputs as sampled in EXEC
//   wb_info_t    the subset of exu_pkt_t that must survive until MEM/WB
package ysyx_25020047_pkg;

    localparam int unsigned XLEN                = 32;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h8000_0000;
    localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT_I = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_GOOD    = 2'b01,
        HC_ABORT   = 2'b10,
        HC_TIMEOUT = 2'b11
    } halt_code_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            read;
        logic            write;
        logic            reg_wen;
        logic            pc_from_res;
        logic            ebreak;
        logic            illegal;
    } exu_pkt_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            write;
        logic            reg_wen;
        logic            pc_from_res;
    } wb_info_t;

    // States in which the sequencer waits on an external responder
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_WAIT_I) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/ysyx_25020047_seq_if.sv
// Bus between the sequencer core and its environment (IFU, IDU/EXU, LSU, debug).
// Modports:
//   master  the sequencer: drives requests, pc, rf_wen, halt status, state_o
//   slave   the environment: drives fetch/memory responses and decoded EXU flags
interface ysyx_25020047_seq_if;
    import ysyx_25020047_pkg::*;

    // Instruction fetch
    logic            ifu_req;
    logic            ifu_rvalid;

    // Decoded / executed instruction
    logic [XLEN-1:0] exu_result;
    logic            exu_read;
    logic            exu_write;
    logic            exu_reg_wen;
    logic            pc_from_res;
    logic            ebreak;
    logic            illegal;

    // Load/store unit
    logic            lsu_req;
    logic            lsu_we;
    logic            lsu_ack;

    // Architectural / status
    logic [XLEN-1:0] pc;
    logic            rf_wen;
    logic            halt;
    logic [1:0]      halt_code;
    logic [2:0]      state_o;

    modport master (
        output ifu_req, lsu_req, lsu_we, pc, rf_wen, halt, halt_code, state_o,
        input  ifu_rvalid, exu_result, exu_read, exu_write, exu_reg_wen,
               pc_from_res, ebreak, illegal, lsu_ack
    );

    modport slave (
        input  ifu_req, lsu_req, lsu_we, pc, rf_wen, halt, halt_code, state_o,
        output ifu_rvalid, exu_result, exu_read, exu_write, exu_reg_wen,
               pc_from_res, ebreak, illegal, lsu_ack
    );

endinterface

// File: rtl/ysyx_25020047_wdog.sv
// Response watchdog: counts cycles spent waiting on a fetch or memory response.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     restart the count (asserted on the edge that enters a wait state)
//   enable    one more cycle elapsed without a response
//   expired   LIMIT waiting cycles have elapsed, including the current one
module ysyx_25020047_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count k-1 is held during the k-th waiting cycle, so LAST marks the LIMIT-th one
    assign expired = (cnt_q == LAST);

    // Saturating count; clear wins so a new wait always starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_25020047_seq.sv
// Multi-cycle instruction sequencer: FETCH -> WAIT_I -> EXEC -> [MEM] -> WB, with
// an absorbing HALT for ebreak, illegal instructions and response timeouts.
// Ports:
//   clk, rst  sole clock and synchronous active-high reset
//   bus       master side of ysyx_25020047_seq_if (fetch, EXU flags, LSU, pc, status)
// Parameters:
//   RESET_PC     pc loaded on reset
//   MEM_TIMEOUT  waiting cycles allowed for ifu_rvalid / lsu_ack before halting
module ysyx_25020047_seq
    import ysyx_25020047_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_25020047_seq_if.master bus
);

    state_e          state_q;
    state_e          state_d;

    wb_info_t        wb_q;
    wb_info_t        wb_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    logic            ifu_req_q;
    logic            ifu_req_d;
    logic            lsu_req_q;
    logic            lsu_req_d;
    logic            lsu_we_q;
    logic            lsu_we_d;
    logic            rf_wen_q;
    logic            rf_wen_d;
    logic            halt_q;
    logic            halt_d;
    halt_code_e      halt_code_q;
    halt_code_e      halt_code_d;

    exu_pkt_t        exu_in;
    logic            exec_abort_c;
    logic            response_c;
    logic            wd_clear;
    logic            wd_enable;
    logic            wd_expired;

    // Gather the decoded instruction into one payload
    always_comb begin
        exu_in             = '0;
        exu_in.result      = bus.exu_result;
        exu_in.read        = bus.exu_read;
        exu_in.write       = bus.exu_write;
        exu_in.reg_wen     = bus.exu_reg_wen;
        exu_in.pc_from_res = bus.pc_from_res;
        exu_in.ebreak      = bus.ebreak;
        exu_in.illegal     = bus.illegal;
    end

    // A load that is also a store cannot be issued; treat it like an unknown opcode
    assign exec_abort_c = exu_in.illegal || (exu_in.read && exu_in.write);

    // Responses only count in the state that is waiting for them
    assign response_c = ((state_q == ST_WAIT_I) && bus.ifu_rvalid) ||
                        ((state_q == ST_MEM)    && bus.lsu_ack);

    assign wd_clear  = is_wait_state(state_d) && (state_d != state_q);
    assign wd_enable = is_wait_state(state_q) && !response_c;

    ysyx_25020047_wdog #(
        .LIMIT   (MEM_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Stay until the request has been on the bus for a cycle; after reset
            // this delays the first request to the first cycle out of reset
            ST_FETCH: begin
                if (ifu_req_q) begin
                    state_d = ST_WAIT_I;
                end
            end
            ST_WAIT_I: begin
                if (bus.ifu_rvalid) begin
                    state_d = ST_EXEC;
                end else if (wd_expired) begin
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (exec_abort_c || exu_in.ebreak) begin
                    state_d = ST_HALT;
                end else if (exu_in.read || exu_in.write) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.lsu_ack) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Output / datapath next values; every strobe is a flop loaded from state_d
    always_comb begin
        ifu_req_d   = (state_d == ST_FETCH);
        lsu_req_d   = (state_d == ST_MEM);
        lsu_we_d    = 1'b0;
        rf_wen_d    = 1'b0;
        halt_d      = (state_d == ST_HALT);
        halt_code_d = halt_code_q;
        wb_d        = wb_q;
        pc_d        = pc_q;

        case (state_q)
            ST_EXEC: begin
                wb_d.result      = exu_in.result;
                wb_d.write       = exu_in.write;
                wb_d.reg_wen     = exu_in.reg_wen;
                wb_d.pc_from_res = exu_in.pc_from_res;
                lsu_we_d         = (state_d == ST_MEM) && exu_in.write;
                rf_wen_d         = (state_d == ST_WB) && exu_in.reg_wen;
                if (state_d == ST_HALT) begin
                    halt_code_d = exec_abort_c ? HC_ABORT : HC_GOOD;
                end
            end
            ST_WAIT_I: begin
                if (state_d == ST_HALT) begin
                    halt_code_d = HC_TIMEOUT;
                end
            end
            ST_MEM: begin
                lsu_we_d = (state_d == ST_MEM) && wb_q.write;
                rf_wen_d = (state_d == ST_WB) && wb_q.reg_wen;
                if (state_d == ST_HALT) begin
                    halt_code_d = HC_TIMEOUT;
                end
            end
            // pc advances only here; the +4 wraps modulo 2^32
            ST_WB: begin
                pc_d = wb_q.pc_from_res ? wb_q.result : (pc_q + 32'd4);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            wb_q        <= '0;
            ifu_req_q   <= 1'b0;
            lsu_req_q   <= 1'b0;
            lsu_we_q    <= 1'b0;
            rf_wen_q    <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= HC_NONE;
        end else begin
            pc_q        <= pc_d;
            wb_q        <= wb_d;
            ifu_req_q   <= ifu_req_d;
            lsu_req_q   <= lsu_req_d;
            lsu_we_q    <= lsu_we_d;
            rf_wen_q    <= rf_wen_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
        end
    end

    assign bus.ifu_req   = ifu_req_q;
    assign bus.lsu_req   = lsu_req_q;
    assign bus.lsu_we    = lsu_we_q;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.pc        = pc_q;
    assign bus.halt      = halt_q;
    assign bus.halt_code = halt_code_q;
    assign bus.state_o   = 3'(state_q);

endmodule

// File: tb/tb_ysyx_25020047_seq.sv
// Testbench for ysyx_25020047_seq: scripted and randomized instructions checked
// cycle by cycle against a per-instruction timeline derived from the sequencer rules.
module tb_ysyx_25020047_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 20;

    logic clk = 1'b0;
    logic rst;

    ysyx_25020047_seq_if bus();

    ysyx_25020047_seq #(
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_rvalid  = 1'b0;
        bus.lsu_ack     = 1'b0;
        bus.exu_result  = 32'h0;
        bus.exu_read    = 1'b0;
        bus.exu_write   = 1'b0;
        bus.exu_reg_wen = 1'b0;
        bus.pc_from_res = 1'b0;
        bus.ebreak      = 1'b0;
        bus.illegal     = 1'b0;
    endtask

    // Reset for one edge, check the reset state, release; ends on the first FETCH cycle
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", bus.state_o);
        end
        checks++;
        if (bus.pc !== RST_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, RST_PC);
        end
        checks++;
        if ({bus.ifu_req, bus.lsu_req, bus.lsu_we, bus.rf_wen, bus.halt} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 00000",
                               {bus.ifu_req, bus.lsu_req, bus.lsu_we, bus.rf_wen, bus.halt});
        end
        checks++;
        if (bus.halt_code !== 2'b00) begin
            errors++; $display("FAIL reset_halt_code: got %b want 00", bus.halt_code);
        end
        rst = 1'b0;
        tick();
        model_pc = RST_PC;
    endtask

    // One instruction starting at its FETCH cycle (c = 0). fd: extra cycles before
    // ifu_rvalid (>= TO means never); ad: extra MEM cycles before lsu_ack (>= TO means never).
    task automatic run_instr(input bit rd, input bit wr, input bit rwen, input bit pfr,
                             input bit ebrk, input bit ill, input logic [31:0] res,
                             input int fd, input int ad, input bit strays);
        bit         fd_ok;
        int         wait_end, exec, halt_at, wb, mem_lo, mem_hi, last;
        logic [1:0] code;
        logic [2:0] es;
        bit         e_lsu, e_rf, e_halt;

        fd_ok    = (fd < TO);
        wait_end = fd_ok ? fd + 1 : TO;
        exec     = fd + 2;
        halt_at  = -1;
        wb       = -1;
        mem_lo   = -1;
        mem_hi   = -2;
        code     = 2'b00;
        if (!fd_ok) begin
            halt_at = TO + 1; code = 2'b11;
        end else if (ill || (rd && wr)) begin
            halt_at = exec + 1; code = 2'b10;
        end else if (ebrk) begin
            halt_at = exec + 1; code = 2'b01;
        end else if (rd || wr) begin
            mem_lo = exec + 1;
            if (ad < TO) begin
                mem_hi = exec + 1 + ad; wb = mem_hi + 1;
            end else begin
                mem_hi = exec + TO; halt_at = mem_hi + 1; code = 2'b11;
            end
        end else begin
            wb = exec + 1;
        end
        last = (halt_at >= 0) ? halt_at + 3 : wb;

        for (int c = 0; c <= last; c++) begin
            bus.ifu_rvalid = (fd_ok && c == fd + 1) ||
                             (strays && ($urandom_range(0, 3) == 0) && (c == 0 || c > wait_end));
            bus.lsu_ack    = ((mem_lo >= 0) && (ad < TO) && (c == mem_hi)) ||
                             (strays && ($urandom_range(0, 3) == 0) && !(c >= mem_lo && c <= mem_hi));
            if (fd_ok && c == exec) begin
                bus.exu_result  = res;
                bus.exu_read    = rd;
                bus.exu_write   = wr;
                bus.exu_reg_wen = rwen;
                bus.pc_from_res = pfr;
                bus.ebreak      = ebrk;
                bus.illegal     = ill;
            end else begin
                bus.exu_result  = $urandom;
                bus.exu_read    = 1'($urandom_range(0, 1));
                bus.exu_write   = 1'($urandom_range(0, 1));
                bus.exu_reg_wen = 1'($urandom_range(0, 1));
                bus.pc_from_res = 1'($urandom_range(0, 1));
                bus.ebreak      = 1'($urandom_range(0, 1));
                bus.illegal     = 1'($urandom_range(0, 1));
            end

            e_halt = (halt_at >= 0) && (c >= halt_at);
            e_lsu  = (c >= mem_lo) && (c <= mem_hi);
            e_rf   = (wb >= 0) && (c == wb) && rwen;
            if (e_halt)              es = 3'd5;
            else if (c == 0)         es = 3'd0;
            else if (c <= wait_end)  es = 3'd1;
            else if (c == exec)      es = 3'd2;
            else if (e_lsu)          es = 3'd3;
            else                     es = 3'd4;

            checks++;
            if (bus.state_o !== es) begin
                errors++; $display("FAIL state_o c%0d: got %0d want %0d", c, bus.state_o, es);
            end
            checks++;
            if (bus.ifu_req !== (c == 0)) begin
                errors++; $display("FAIL ifu_req c%0d: got %b want %b", c, bus.ifu_req, (c == 0));
            end
            checks++;
            if (bus.lsu_req !== e_lsu) begin
                errors++; $display("FAIL lsu_req c%0d: got %b want %b", c, bus.lsu_req, e_lsu);
            end
            if (e_lsu) begin
                checks++;
                if (bus.lsu_we !== wr) begin
                    errors++; $display("FAIL lsu_we c%0d: got %b want %b", c, bus.lsu_we, wr);
                end
            end
            checks++;
            if (bus.rf_wen !== e_rf) begin
                errors++; $display("FAIL rf_wen c%0d: got %b want %b", c, bus.rf_wen, e_rf);
            end
            checks++;
            if (bus.halt !== e_halt) begin
                errors++; $display("FAIL halt c%0d: got %b want %b", c, bus.halt, e_halt);
            end
            checks++;
            if (bus.halt_code !== (e_halt ? code : 2'b00)) begin
                errors++; $display("FAIL halt_code c%0d: got %b want %b", c, bus.halt_code,
                                   (e_halt ? code : 2'b00));
            end
            checks++;
            if (bus.pc !== model_pc) begin
                errors++; $display("FAIL pc c%0d: got %h want %h", c, bus.pc, model_pc);
            end
            tick();
        end
        if (halt_at < 0) model_pc = pfr ? res : model_pc + 32'd4;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_addi();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 1, 0, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0100, 2, 0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 0, 0, 1'b0);
    endtask

    task automatic test_load_store();
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 1, 3, 1'b0);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 0, 0, 1'b0);
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 0, TO - 1, 1'b1);
    endtask

    task automatic test_pc_wrap();
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 0, 0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 0, 0, 1'b0);
    endtask

    task automatic test_fetch_boundary();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, TO - 1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            run_instr(kind == 2, kind == 3, (kind != 3) && ($urandom_range(0, 3) != 0),
                      kind == 1, 1'b0, 1'b0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1);
        end
    endtask

    task automatic test_reset_in_mem();
        idle_inputs();
        tick();                          // FETCH
        bus.ifu_rvalid = 1'b1;
        tick();                          // WAIT_I
        bus.ifu_rvalid  = 1'b0;
        bus.exu_read    = 1'b1;
        bus.exu_reg_wen = 1'b1;
        tick();                          // EXEC
        idle_inputs();
        checks++;
        if (bus.lsu_req !== 1'b1) begin
            errors++; $display("FAIL rst_mem_lsu_req: got %b want 1", bus.lsu_req);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.lsu_req !== 1'b0 || bus.state_o !== 3'd0 || bus.pc !== RST_PC) begin
            errors++; $display("FAIL rst_mem_abandon: got req=%b st=%0d pc=%h want req=0 st=0 pc=%h",
                               bus.lsu_req, bus.state_o, bus.pc, RST_PC);
        end
        rst = 1'b0;
        bus.lsu_ack = 1'b1;              // late ack for the abandoned load
        tick();
        model_pc = RST_PC;
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 1, 0, 1'b0);
    endtask

    task automatic test_ebreak();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, $urandom, 1, 0, 1'b1);
        do_reset();
    endtask

    task automatic test_illegal();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, $urandom, 0, 0, 1'b1);
        do_reset();
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 2, 0, 1'b0);
        do_reset();
    endtask

    task automatic test_fetch_timeout();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 1000, 0, 1'b0);
        do_reset();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 0, 0, 1'b0);
    endtask

    task automatic test_mem_timeout();
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1, 1000, 1'b1);
        do_reset();
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, 0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_addi();
        test_branch();
        test_load_store();
        test_pc_wrap();
        test_fetch_boundary();
        test_random();
        test_reset_in_mem();
        test_ebreak();
        test_illegal();
        test_fetch_timeout();
        test_mem_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
